// File: rtl/csa_operand_collector.sv
// Collects M operands for the carry-save adder, then registers its {Cout, Sum} result on a valid/ready output.
// Latency: one CALC cycle after the last operand is accepted; in_ready is held low from CALC until the result is taken.
module csa_operand_collector #(
  parameter int M = 6,
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     Operands [M-1:0],
  input  logic [N+M-3:0]   csa_sum,
  input  logic             csa_cout,
  output logic [N+M-2:0]   out_sum,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(M);
  localparam int SW = N + M - 1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CALC    = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    ops_q [M-1:0];
  logic [N-1:0]    ops_d [M-1:0];
  logic [SW-1:0]   sum_q, sum_d;
  logic            vld_q, vld_d;

  logic            in_fire;
  logic            out_fire;
  logic            last_beat;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = vld_q & out_ready;
  assign last_beat = (cnt_q == CW'(M - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (in_fire && last_beat) state_d = CALC;
      CALC:    state_d = DONE;
      DONE:    if (out_fire) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Output decode: in_ready depends on state only, never on an input
  always_comb begin
    in_ready = (state_q == COLLECT);
  end

  always_comb begin
    cnt_d = cnt_q;
    sum_d = sum_q;
    vld_d = vld_q;
    for (int i = 0; i < M; i++) begin
      ops_d[i] = ops_q[i];
    end

    if (in_fire) begin
      for (int i = 0; i < M; i++) begin
        if (cnt_q == CW'(i)) ops_d[i] = in_data;
      end
      cnt_d = last_beat ? '0 : cnt_q + 1'b1;
    end

    // The CSA has had a full cycle to settle on the registered operand bus
    if (state_q == CALC) begin
      sum_d = {csa_cout, csa_sum};
      vld_d = 1'b1;
    end

    // Clearing the bus keeps slots of the next load at zero until written
    if (out_fire) begin
      vld_d = 1'b0;
      for (int i = 0; i < M; i++) begin
        ops_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sum_q <= '0;
      vld_q <= 1'b0;
      for (int i = 0; i < M; i++) begin
        ops_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      vld_q <= vld_d;
      for (int i = 0; i < M; i++) begin
        ops_q[i] <= ops_d[i];
      end
    end
  end

  assign Operands  = ops_q;
  assign out_sum   = sum_q;
  assign out_valid = vld_q;

endmodule
